// File: rtl/uart_rx.sv
// UART 8N1 receiver with a small byte FIFO, read and cleared over the picorv32 native memory bus.
// Latency: a byte is visible in STATUS one cycle after its stop-bit sample; bus accesses ack one cycle after request.
// Backpressure: none toward the line; a byte arriving while the FIFO is full is dropped and flagged as overrun.
module uart_rx #(
    parameter int CLK_HZ     = 100000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        enable,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    input  logic        serialIn
);

    localparam int BIT_CYCLES = CLK_HZ / BAUD;
    localparam int CW         = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;
    localparam int AW         = $clog2(FIFO_DEPTH);
    localparam int PW         = AW + 1;

    localparam logic [CW-1:0] CNT_HALF = CW'(BIT_CYCLES / 2 - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(BIT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    // Line synchroniser and edge detection
    logic       sync_q1;
    logic       sync_q2;
    logic [1:0] settle;
    logic       line_prev;
    logic       line;
    logic       line_fall;

    // Receive FSM
    state_t          state;
    logic [CW-1:0]   cnt;
    logic [2:0]      bitidx;
    logic [7:0]      shreg;

    // FIFO and flags
    logic [7:0]      fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]   wptr;
    logic [PW-1:0]   rptr;
    logic            fifo_empty;
    logic            fifo_full;
    logic            overrun;
    logic            framing_err;

    // Decoded events
    logic            is_status;
    logic            is_write;
    logic            pop;
    logic            stop_ok;
    logic            stop_bad;
    logic            push_ok;
    logic            ovr_set;
    logic            clr_ovr;
    logic            clr_fe;

    logic            unused;
    assign unused = ^{mem_instr, mem_addr[31:3], mem_addr[1:0], mem_wdata[31:3], mem_wdata[0]};

    // Two-flop synchroniser; the edge detector is only armed once real line samples have
    // flushed through, so a line held low across reset release cannot fake a start bit.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync_q1   <= 1'b1;
            sync_q2   <= 1'b1;
            settle    <= 2'b00;
            line_prev <= 1'b0;
        end else begin
            sync_q1 <= serialIn;
            sync_q2 <= sync_q1;
            settle  <= {settle[0], 1'b1};
            if (settle[1]) begin
                line_prev <= sync_q2;
            end
        end
    end

    assign line      = sync_q2;
    assign line_fall = settle[1] & line_prev & ~line;

    // Frame FSM: mid-bit sampling from a half-bit delay after the start edge
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state  <= S_IDLE;
            cnt    <= '0;
            bitidx <= '0;
            shreg  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (line_fall) begin
                        cnt   <= CNT_HALF;
                        state <= S_START;
                    end
                end
                S_START: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else if (!line) begin
                        cnt    <= CNT_FULL;
                        bitidx <= 3'd0;
                        state  <= S_DATA;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_DATA: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        shreg[bitidx] <= line;
                        cnt           <= CNT_FULL;
                        if (bitidx == 3'd7) begin
                            state <= S_STOP;
                        end else begin
                            bitidx <= bitidx + 3'd1;
                        end
                    end
                end
                S_STOP: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else if (line) begin
                        state <= S_IDLE;
                    end else begin
                        state <= S_BREAK;
                    end
                end
                S_BREAK: begin
                    if (line) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign stop_ok  = (state == S_STOP) && (cnt == '0) && line;
    assign stop_bad = (state == S_STOP) && (cnt == '0) && !line;

    assign fifo_empty = (wptr == rptr);
    assign fifo_full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

    assign is_status = mem_addr[2];
    assign is_write  = |mem_wstrb;
    assign pop       = mem_ready && !is_status && !is_write && !fifo_empty;
    assign clr_ovr   = mem_ready && is_status && is_write && mem_wdata[1];
    assign clr_fe    = mem_ready && is_status && is_write && mem_wdata[2];

    // A pop in the same cycle frees the slot, so a push into a full FIFO then still lands
    assign push_ok = stop_ok && (!fifo_full || pop);
    assign ovr_set = stop_ok && fifo_full && !pop;

    // Single-cycle acknowledge, one cycle after each selected request
    always_ff @(posedge clk) begin
        if (!resetn) begin
            mem_ready <= 1'b0;
        end else begin
            mem_ready <= mem_valid && enable && !mem_ready;
        end
    end

    // FIFO pointers and sticky flags; a hardware set beats a software clear
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wptr        <= '0;
            rptr        <= '0;
            overrun     <= 1'b0;
            framing_err <= 1'b0;
        end else begin
            if (push_ok) begin
                wptr <= wptr + PW'(1);
            end
            if (pop) begin
                rptr <= rptr + PW'(1);
            end
            overrun     <= ovr_set  | (overrun & ~clr_ovr);
            framing_err <= stop_bad | (framing_err & ~clr_fe);
        end
    end

    // FIFO storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wptr[AW-1:0]] <= shreg;
        end
    end

    // Read data is driven only during a read acknowledge
    always_comb begin
        mem_rdata = 32'h0;
        if (mem_ready && !is_write) begin
            if (is_status) begin
                mem_rdata = {28'h0, fifo_full, framing_err, overrun, ~fifo_empty};
            end else if (!fifo_empty) begin
                mem_rdata = {24'h0, fifo_mem[rptr[AW-1:0]]};
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: constant vector table, hand-written corner sequences,
// and a randomized phase compared against a queue-based model of the receiver.
module tb_uart_rx;

    localparam int CLK_HZ = 1600000;
    localparam int BAUD   = 100000;
    localparam int DEPTH  = 4;

    logic        clk       = 1'b0;
    logic        resetn    = 1'b0;
    logic        enable    = 1'b0;
    logic        mem_valid = 1'b0;
    logic        mem_instr = 1'b0;
    logic [31:0] mem_addr  = 32'h0;
    logic [3:0]  mem_wstrb = 4'h0;
    logic [31:0] mem_wdata = 32'h0;
    logic        serialIn  = 1'b1;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: received bytes and sticky flags
    logic [7:0] q[$];
    bit         m_ovr;
    bit         m_fe;

    uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .enable    (enable),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_instr (mem_instr),
        .mem_addr  (mem_addr),
        .mem_wstrb (mem_wstrb),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .serialIn  (serialIn)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    // Bus access; entered and left just after a falling clock edge
    task automatic bus(input bit status, input bit wr, input logic [31:0] wd, output logic [31:0] rd);
        mem_valid = 1'b1;
        enable    = 1'b1;
        mem_addr  = status ? 32'h4 : 32'h0;
        mem_wstrb = wr ? 4'hF : 4'h0;
        mem_wdata = wd;
        rd        = 32'h0;
        @(negedge clk);
        check("ack_latency", {31'h0, mem_ready}, 32'h1);
        if (mem_ready !== 1'b1) begin
            for (int w = 0; w < 8 && mem_ready !== 1'b1; w++) @(negedge clk);
            if (mem_ready !== 1'b1) begin
                check("ack_timeout", {31'h0, mem_ready}, 32'h1);
                mem_valid = 1'b0;
                enable    = 1'b0;
                mem_wstrb = 4'h0;
                return;
            end
        end
        rd = mem_rdata;
        @(negedge clk);
        check("ack_width", {31'h0, mem_ready}, 32'h0);
        check("rdata_idle", mem_rdata, 32'h0);
        mem_valid = 1'b0;
        enable    = 1'b0;
        mem_wstrb = 4'h0;
    endtask

    task automatic rd_status(input string name, input logic [31:0] exp);
        logic [31:0] r;
        bus(1'b1, 1'b0, 32'h0, r);
        check(name, r, exp);
    endtask

    task automatic rd_data(input string name, input logic [31:0] exp);
        logic [31:0] r;
        bus(1'b0, 1'b0, 32'h0, r);
        check(name, r, exp);
    endtask

    task automatic wr_status(input logic [31:0] wd);
        logic [31:0] r;
        bus(1'b1, 1'b1, wd, r);
    endtask

    // One 8N1 frame, one bit per 16 cycles; stop_low>0 holds the stop bit low that long;
    // abort_at>0 returns the line to idle at that cycle of the frame.
    task automatic send_frame(input logic [7:0] b, input int stop_low, input int abort_at);
        int total;
        total = 144 + stop_low + 16;
        for (int c = 0; c < total; c++) begin
            if (abort_at > 0 && c == abort_at) break;
            if (c < 16)                  serialIn = 1'b0;
            else if (c < 144)            serialIn = b[(c - 16) / 16];
            else if (c < 144 + stop_low) serialIn = 1'b0;
            else                         serialIn = 1'b1;
            @(negedge clk);
        end
        serialIn = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    function automatic logic [31:0] m_status();
        return {28'h0, q.size() == DEPTH, m_fe, m_ovr, q.size() != 0};
    endfunction

    task automatic m_send(input logic [7:0] b, input bit bad);
        send_frame(b, bad ? 20 : 0, 0);
        if (bad)                  m_fe = 1'b1;
        else if (q.size() == DEPTH) m_ovr = 1'b1;
        else                      q.push_back(b);
    endtask

    typedef struct {
        logic [7:0]  data;
        int          stop_low;
        logic [31:0] st_rx;
        logic [31:0] dat;
        logic [31:0] st_after;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [31:0] r;

        vecs[0] = '{8'h55, 0,  32'h1, 32'h55, 32'h0};
        vecs[1] = '{8'hA3, 20, 32'h4, 32'h00, 32'h4};
        vecs[2] = '{8'h3C, 0,  32'h1, 32'h3C, 32'h0};
        vecs[3] = '{8'h00, 0,  32'h1, 32'h00, 32'h0};
        vecs[4] = '{8'hFF, 0,  32'h1, 32'hFF, 32'h0};
        vecs[5] = '{8'h80, 0,  32'h1, 32'h80, 32'h0};

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_ready", {31'h0, mem_ready}, 32'h0);
        check("reset_rdata", mem_rdata, 32'h0);
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        rd_status("reset_status", 32'h0);

        // Table of single frames: clean bytes and a framing error
        for (int i = 0; i < 6; i++) begin
            send_frame(vecs[i].data, vecs[i].stop_low, 0);
            rd_status($sformatf("vec%0d_status", i), vecs[i].st_rx);
            rd_data($sformatf("vec%0d_data", i), vecs[i].dat);
            rd_status($sformatf("vec%0d_status_after", i), vecs[i].st_after);
            wr_status(32'h4);
            rd_status($sformatf("vec%0d_status_clr", i), 32'h0);
        end

        // False start: short low glitch, then a normal frame still works
        serialIn = 1'b0;
        repeat (5) @(negedge clk);
        serialIn = 1'b1;
        repeat (30) @(negedge clk);
        rd_status("glitch_status", 32'h0);
        send_frame(8'h5A, 0, 0);
        rd_status("glitch_next_status", 32'h1);
        rd_data("glitch_next_data", 32'h5A);

        // Read while empty
        rd_data("empty_read", 32'h0);
        rd_status("empty_status", 32'h0);

        // Overrun and pointer wrap
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 0, 0);
        rd_status("ovr_status", 32'hB);
        for (int i = 1; i <= 4; i++) rd_data($sformatf("ovr_data%0d", i), 32'(i));
        rd_data("ovr_data_empty", 32'h0);
        rd_status("ovr_status_after", 32'h2);
        wr_status(32'h2);
        rd_status("ovr_status_clr", 32'h0);
        for (int i = 6; i <= 9; i++) send_frame(8'(i), 0, 0);
        rd_status("wrap_status", 32'h9);
        for (int i = 6; i <= 9; i++) rd_data($sformatf("wrap_data%0d", i), 32'(i));
        rd_status("wrap_status_after", 32'h0);

        // Pop coincides with the stop-bit push while full
        for (int i = 0; i < 4; i++) send_frame(8'h10 + 8'(i), 0, 0);
        rd_status("coin_full", 32'h9);
        fork
            send_frame(8'h14, 0, 0);
            begin
                repeat (153) @(negedge clk);
                bus(1'b0, 1'b0, 32'h0, r);
                check("coin_pop", r, 32'h10);
            end
        join
        rd_status("coin_status", 32'h9);
        for (int i = 1; i <= 4; i++) rd_data($sformatf("coin_data%0d", i), 32'h10 + 32'(i));
        rd_status("coin_status_after", 32'h0);

        // Reset mid-byte with a byte already buffered
        send_frame(8'h77, 0, 0);
        rd_status("mid_pre_status", 32'h1);
        fork
            send_frame(8'h99, 0, 60);
            begin
                repeat (50) @(negedge clk);
                resetn = 1'b0;
                @(negedge clk);
                check("mid_reset_ready", {31'h0, mem_ready}, 32'h0);
                check("mid_reset_rdata", mem_rdata, 32'h0);
                resetn = 1'b1;
            end
        join
        repeat (20) @(negedge clk);
        rd_status("mid_status", 32'h0);
        send_frame(8'hC3, 0, 0);
        rd_status("mid_next_status", 32'h1);
        rd_data("mid_next_data", 32'hC3);
        rd_status("mid_next_after", 32'h0);

        // Randomized traffic against the model
        q.delete();
        m_ovr = 1'b0;
        m_fe  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            int unsigned op;
            op = $urandom_range(0, 9);
            if (op <= 3) begin
                logic [7:0] b;
                b = 8'($urandom_range(0, 255));
                m_send(b, (op == 3) && ($urandom_range(0, 1) == 1));
            end else if (op <= 6) begin
                logic [31:0] exp;
                exp = (q.size() != 0) ? {24'h0, q.pop_front()} : 32'h0;
                rd_data($sformatf("rand%0d_data", i), exp);
            end else if (op <= 8) begin
                rd_status($sformatf("rand%0d_status", i), m_status());
            end else begin
                logic [2:0] rw;
                rw = 3'($urandom_range(0, 7));
                wr_status({29'h0, rw});
                if (rw[1]) m_ovr = 1'b0;
                if (rw[2]) m_fe  = 1'b0;
            end
        end
        rd_status("rand_final_status", m_status());
        while (q.size() != 0) begin
            logic [31:0] exp;
            exp = {24'h0, q.pop_front()};
            rd_data("rand_drain", exp);
        end
        rd_data("rand_drain_empty", 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Memory-mapped UART receiver on the picorv32 native memory bus; receive-side counterpart of uartTx.
- Deserialises 8N1 frames from serialIn, LSB first, and buffers received bytes in a small FIFO.
- The CPU reads bytes and status through the same mem_valid/mem_ready handshake as the other peripherals.
- Selected by busInterface via enable. Its mem_ready and mem_rdata are merged into the bus there.

Parameters:
- CLK_HZ, 100000000, clk frequency in Hz.
- BAUD, 115200, line rate. BIT_CYCLES = CLK_HZ/BAUD (integer divide; 868 at defaults).
- FIFO_DEPTH, 4, receive FIFO entries. Must be a power of 2, at least 2.

Ports:
- clk  input  1  system clock.
- resetn  input  1  synchronous, active-low reset.
- enable  input  1  address-decode select from busInterface.
- mem_valid  input  1  bus request valid.
- mem_ready  output  1  one-cycle acknowledge.
- mem_instr  input  1  ignored.
- mem_addr  input  32  bit 2 selects the register; all other bits ignored.
- mem_wstrb  input  4  nonzero = write.
- mem_wdata  input  32  write data.
- mem_rdata  output  32  read data, valid only while mem_ready is high, otherwise 0.
- serialIn  input  1  asynchronous RX line, idle high.

Behaviour:
- Reset: mem_ready=0, mem_rdata=0, FIFO empty, overrun=0, framing_err=0, FSM=IDLE, synchroniser flops=1.
- Input sync: serialIn passes through 2 flops before any use. Edge detection uses the synchronised value and its previous value.
- Bus handshake:
  - When mem_valid && enable && !mem_ready, mem_ready=1 on the next cycle, for exactly 1 cycle.
  - Access side effects take place in the cycle mem_ready is high.
  - Back-to-back requests are therefore acked every 2 cycles.
- Registers:
  - addr[2]=0 DATA, read: {24'b0, head byte}. A read pops one entry if the FIFO is not empty. A read while empty returns 0 and pops nothing.
  - addr[2]=0 DATA, write: ignored, still acked.
  - addr[2]=1 STATUS, read: {28'b0, full, framing_err, overrun, not_empty}.
  - addr[2]=1 STATUS, write: wdata[1]=1 clears overrun; wdata[2]=1 clears framing_err. Other bits are ignored.
- FSM states, with a bit counter cnt (clog2(BIT_CYCLES) bits) and bitidx (3 bits):
  - IDLE: on a falling edge of the synced line, cnt=BIT_CYCLES/2-1, go to START.
  - START: count cnt to 0. At 0, sample the line:
    - low: cnt=BIT_CYCLES-1, bitidx=0, go to DATA;
    - high: false start, go to IDLE.
  - DATA: at cnt==0, shift the sample into shreg bit bitidx and reload cnt. After bitidx==7, go to STOP.
  - STOP: at cnt==0, sample the line:
    - high: push shreg into the FIFO and go to IDLE.
    - low: set framing_err, discard the byte, go to BREAK.
  - BREAK: wait until the synced line is high, then go to IDLE.
- FIFO:
  - Pointers are log2(FIFO_DEPTH)+1 bits wide and wrap naturally.
  - full when the pointer MSBs differ and the lower bits are equal.
  - Push while full: byte dropped, overrun set, contents unchanged.
  - Push and pop in the same cycle: both take effect and the count is unchanged. If the FIFO is full, this case is not an overrun (the pop frees the slot first).
  - Pop and push in the same cycle while empty: the read returns 0 and the new byte is stored.
- Sticky flags: overrun and framing_err stay set until cleared by a write or by reset. A hardware set in the same cycle as a clear wins (flag stays 1).
- Reset mid-frame: the FSM returns to IDLE and the partial byte is discarded. A low line at reset release does not start a frame until a falling edge is seen.
- Latency: a byte becomes visible in STATUS.not_empty 1 cycle after the stop-bit sample.

Test Plan (CLK_HZ=1600000, BAUD=100000, so BIT_CYCLES=16; FIFO_DEPTH=4):
- Clean frame:
  - Drive 0x55 in 8N1, then read STATUS, then read DATA.
  - Required: STATUS=0x1; DATA=0x00000055; next STATUS=0x0.
  - Every mem_ready is 1 cycle wide and arrives 1 cycle after mem_valid.
- False start: a 5-cycle low glitch on serialIn. Required: no byte pushed, STATUS=0x0, FSM back in IDLE.
- Framing error:
  - Send 0xA3 with the stop bit held low for 20 cycles, then high.
  - Required: STATUS=0x4 and FIFO empty.
  - Write STATUS wdata=0x4, then STATUS=0x0. A following 0x3C is received correctly.
- Overrun and wrap:
  - Send 0x01..0x05 without reading.
  - Required: STATUS=0xB (full, overrun, not_empty); reads return 0x01,0x02,0x03,0x04, then 0 with STATUS=0x2.
  - Send 0x06..0x09 and read all four: data is correct across the pointer wrap.
- Read while empty: DATA read with the FIFO empty returns 0x00000000 and the FIFO stays empty.
- Simultaneous events:
  - A pop coincides with the stop-bit push while full: no overrun, count stays 4.
  - Assert resetn=0 mid-byte for 1 cycle: FIFO empties, all outputs return to 0, and the next full frame is received correctly.
